alu_control_mdu: RTL

- Registered, handshaked successor to the single-cycle ALU control decoder.
- Decodes ALUOp/Funct into ALU control, jr and sign, one instruction per accepted handshake.
- Also sequences the multi-cycle MULT/DIV unit: it holds off new instructions with a countdown until the operation completes.
- Sits between the decode stage and the execute stage of the multi-cycle MIPS datapath.

---
 rtl/alu_control_mdu_if.sv | 29 ++
 rtl/alu_control_mdu.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_control_mdu_if.sv
// Handshake bundle between decode and the ALU control / MDU sequencer.
// master = decode side, slave = alu_control_mdu.
interface alu_control_mdu_if #(
  parameter int CTRL_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        ALUOp;
  logic [5:0]        Funct;
  logic              flush;
  logic              out_valid;
  logic [CTRL_W-1:0] alucontrol;
  logic              jr;
  logic              sign;
  logic              mdu_busy;
  logic              illegal;

  modport master (
    output in_valid, ALUOp, Funct, flush,
    input  in_ready, out_valid, alucontrol,
    input  jr, sign, mdu_busy, illegal
  );

  modport slave (
    input  in_valid, ALUOp, Funct, flush,
    output in_ready, out_valid, alucontrol,
    output jr, sign, mdu_busy, illegal
  );
endinterface

// File: rtl/alu_control_mdu.sv
// Registered ALU control decoder that also sequences the MULT/DIV unit.
// Define ALU_CONTROL_ILLEGAL_TRAP_EN to flag illegal ops and trap until flush.
module alu_control_mdu #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_control_mdu_if.slave bus
);

`ifdef ALU_CONTROL_ILLEGAL_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif

  localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] C_OR  = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] C_NOR = CTRL_W'(4'b1100);
  localparam logic [CTRL_W-1:0] C_SLT = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] C_SLL = CTRL_W'(4'b0011);
  localparam logic [CTRL_W-1:0] C_SRL = CTRL_W'(4'b0100);
  localparam logic [CTRL_W-1:0] C_MUL = CTRL_W'(4'b1111);
  localparam logic [CTRL_W-1:0] C_DIV = CTRL_W'(4'b1110);

  localparam logic [CNT_W-1:0] MulLd = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DivLd = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ov_q, ov_d;
  logic              ill_q, ill_d;
  logic              trap_q, trap_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              jr_q, jr_d;
  logic              sign_q, sign_d;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_jr;
  logic              dec_sign;
  logic              dec_mdu;
  logic              dec_div;
  logic              dec_ill;
  logic              ready;
  logic              accept;

  always_comb begin
    dec_ctrl = C_ADD;
    dec_jr   = 1'b0;
    dec_sign = 1'b1;
    dec_mdu  = 1'b0;
    dec_div  = 1'b0;
    dec_ill  = 1'b0;
    unique case (1'b1)
      bus.ALUOp == 3'b000: dec_ctrl = C_ADD;
      bus.ALUOp == 3'b001: dec_ctrl = C_SUB;
      bus.ALUOp == 3'b011: begin
        dec_ctrl = C_AND;
        dec_sign = 1'b0;
      end
      bus.ALUOp == 3'b100: begin
        dec_ctrl = C_OR;
        dec_sign = 1'b0;
      end
      bus.ALUOp == 3'b101: dec_ctrl = C_SLT;
      bus.ALUOp == 3'b010: begin
        unique case (bus.Funct)
          6'd32, 6'd33: dec_ctrl = C_ADD;
          6'd34: dec_ctrl = C_SUB;
          6'd36: dec_ctrl = C_AND;
          6'd37: dec_ctrl = C_OR;
          6'd39: dec_ctrl = C_NOR;
          6'd42: dec_ctrl = C_SLT;
          6'd0:  dec_ctrl = C_SLL;
          6'd2:  dec_ctrl = C_SRL;
          6'd8:  dec_jr   = 1'b1;
          6'd24: begin
            dec_ctrl = C_MUL;
            dec_mdu  = 1'b1;
          end
          6'd26: begin
            dec_ctrl = C_DIV;
            dec_mdu  = 1'b1;
            dec_div  = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign ready  = (state_q != BUSY) && !trap_q;
  assign accept = bus.in_valid && ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ov_d    = 1'b0;
    ill_d   = 1'b0;
    trap_d  = trap_q;
    ctrl_d  = ctrl_q;
    jr_d    = jr_q;
    sign_d  = sign_q;
    unique case (state_q)
      IDLE: state_d = IDLE;
      DONE: state_d = IDLE;
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          ov_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      ctrl_d = dec_ctrl;
      jr_d   = dec_jr;
      sign_d = dec_sign;
      if (dec_mdu) begin
        state_d = BUSY;
        cnt_d   = dec_div ? DivLd : MulLd;
      end else begin
        ov_d   = 1'b1;
        ill_d  = TrapEn && dec_ill;
        trap_d = trap_q || (TrapEn && dec_ill);
      end
    end
    // abort wins over any accept or completion in the same cycle
    if (bus.flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      ov_d    = 1'b0;
      ill_d   = 1'b0;
      trap_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      ill_q   <= 1'b0;
      trap_q  <= 1'b0;
      ctrl_q  <= C_ADD;
      jr_q    <= 1'b0;
      sign_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      ill_q   <= ill_d;
      trap_q  <= trap_d;
      ctrl_q  <= ctrl_d;
      jr_q    <= jr_d;
      sign_q  <= sign_d;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = ov_q && !bus.flush;
  assign bus.illegal    = ill_q && !bus.flush;
  assign bus.alucontrol = ctrl_q;
  assign bus.jr         = jr_q;
  assign bus.sign       = sign_q;
  assign bus.mdu_busy   = (state_q == BUSY);

endmodule
